// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller slice.
//   PC_W / INSTR_W : word-address and instruction widths
//   StRun / StHalt : controller state encoding
//   fetch_entry_t  : {pc, instr} pair held in the fetch queue
//   pc_in_range    : true when a word address lies inside the instruction memory
package fetch_controller_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_in_range(input logic [PC_W-1:0] pc, input int unsigned words);
    return pc < PC_W'(words);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller and its environment.
//   imem_addr / imem_data     : combinational instruction-memory read port
//   redirect / redirect_pc    : taken branch/jump and its word-address target
//   out_valid / out_ready     : handshake for the fetched-instruction stream
//   out_instr / out_pc        : head-of-queue instruction and its word address
//   done                      : controller halted with nothing left to deliver
// master: the fetch controller side. slave: memory/consumer/branch-unit side.
interface fetch_controller_if;

  logic [fetch_controller_pkg::PC_W-1:0]    imem_addr;
  logic [fetch_controller_pkg::INSTR_W-1:0] imem_data;
  logic                                     redirect;
  logic [fetch_controller_pkg::PC_W-1:0]    redirect_pc;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [fetch_controller_pkg::INSTR_W-1:0] out_instr;
  logic [fetch_controller_pkg::PC_W-1:0]    out_pc;
  logic                                     done;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output done
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  done
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs for the fetch controller.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : entry to write
//   pop        : discard the head entry (ignored when empty)
//   flush      : drop all entries; wins over push and pop
//   full/empty : occupancy flags
//   head       : oldest entry, all-zero when empty
module fetch_queue
  import fetch_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_eff, pop_eff;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

  assign pop_eff  = pop & ~empty;
  // A full queue can still take a word when the head leaves in the same cycle.
  assign push_eff = push & (~full | pop_eff);

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_eff) wr_ptr_d = ~wr_ptr_q;
      if (pop_eff)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_eff) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a word-addressed instruction memory from
// RESET_PC, buffers fetched words in a 2-entry queue and hands them to the
// consumer with a valid/ready handshake. Stops (HALT) when the PC leaves the
// memory; a redirect flushes the queue and restarts fetching at redirect_pc.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset, wins over redirect
//   bus   : fetch_controller_if.master (imem port, redirect, output stream, done)
// Parameters:
//   MEM_WORDS : number of instruction words, valid addresses 0..MEM_WORDS-1
//   RESET_PC  : first word address fetched after reset
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned     MEM_WORDS = 64,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  bus
);

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

  logic            pc_ok;
  logic            q_full, q_empty;
  logic            push, pop, flush;
  fetch_entry_t    push_data, head;

  assign pc_ok = pc_in_range(fetch_pc_q, MEM_WORDS);

  assign pop   = ~q_empty & bus.out_ready;
  assign flush = bus.redirect;
  assign push  = (state_q == StRun) & pc_ok & ~bus.redirect & (~q_full | pop);

  assign push_data.pc    = fetch_pc_q;
  assign push_data.instr = bus.imem_data;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) begin
      state_d    = StRun;
      fetch_pc_d = bus.redirect_pc;
    end else if (state_q == StRun) begin
      if (!pc_ok) begin
        // Ran off the end of memory: park here, keep the PC where it stopped.
        state_d = StHalt;
      end else if (push) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .full      (q_full),
    .empty     (q_empty),
    .head      (head)
  );

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = ~q_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.done      = (state_q == StHalt) & q_empty;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller. A reference model advances on each
// rising edge and pushes every word it expects to be fetched into exp_q; a
// separate monitor checks the DUT outputs against exp_q mid-cycle and retires
// the head whenever the consumer accepts it.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  localparam int unsigned MemWords = 64;
  localparam logic [63:0] ResetPc  = 64'd0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_controller_if bus ();

  fetch_controller #(
    .MEM_WORDS (MemWords),
    .RESET_PC  (ResetPc)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [MemWords];
  assign bus.imem_data = (bus.imem_addr < 64'(MemWords)) ? rom[bus.imem_addr[5:0]] : 32'h0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_pc   = '0;
  bit          m_halt = 1'b0;
  bit          chk_en = 1'b0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a program counter walking memory, a halted flag, and a
  // list of words fetched but not yet consumed (at most two of them).
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_pc   = ResetPc;
      m_halt = 1'b0;
    end else if (bus.redirect) begin
      exp_q.delete();
      m_pc   = bus.redirect_pc;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_pc >= 64'(MemWords)) begin
        m_halt = 1'b1;
      end else if (exp_q.size() < 2) begin
        exp_q.push_back('{pc: m_pc, instr: rom[m_pc[5:0]]});
        m_pc = m_pc + 64'd1;
      end
    end
  end

  // Monitor: inputs change on the falling edge, so sample 1 time unit later.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check("imem_addr", bus.imem_addr, m_pc);
      check("done", 64'(bus.done), 64'(m_halt && exp_q.size() == 0));
      if (exp_q.size() != 0) begin
        check("out_pc", bus.out_pc, exp_q[0].pc);
        check("out_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
        if (bus.out_ready) void'(exp_q.pop_front());
      end else begin
        check("out_pc_idle", bus.out_pc, 64'd0);
        check("out_instr_idle", 64'(bus.out_instr), 64'd0);
      end
    end
  end

  task automatic drive(input bit r, input bit rd, input logic [63:0] rpc, input bit rdy);
    @(negedge clk);
    reset           = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, rdy);
  endtask

  initial begin
    for (int i = 0; i < int'(MemWords); i++) begin
      rom[i] = (i % 7 == 5) ? 32'h0 : $urandom;
    end
    rom[1] = 32'h0070_2083;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;

    // Reset state, then streaming at one word per cycle.
    drive(1'b1, 1'b0, 64'd0, 1'b1);
    @(posedge clk);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 64'd0, 1'b1);
    run(10, 1'b1);

    // Consumer stalled right after reset: queue fills, PC parks at 2.
    drive(1'b1, 1'b0, 64'd0, 1'b0);
    run(5, 1'b0);
    run(6, 1'b1);

    // Redirect to 10 while the queue is full.
    drive(1'b1, 1'b0, 64'd0, 1'b1);
    run(3, 1'b1);
    run(3, 1'b0);
    drive(1'b0, 1'b1, 64'd10, 1'b0);
    run(4, 1'b1);

    // Run off the end of memory and drain.
    run(70, 1'b1);
    run(3, 1'b1);

    // Redirect out of HALT, then a redirect straight past the end.
    drive(1'b0, 1'b1, 64'd5, 1'b1);
    run(4, 1'b1);
    drive(1'b0, 1'b1, 64'd70, 1'b1);
    run(3, 1'b1);
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run(3, 1'b1);

    // Reset mid-stream with the queue full and a redirect also asserted.
    drive(1'b0, 1'b1, 64'd20, 1'b1);
    run(3, 1'b0);
    drive(1'b1, 1'b1, 64'd40, 1'b0);
    run(5, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 150) == 0, ($urandom % 100) < 4, 64'($urandom_range(0, 70)),
            ($urandom % 100) < 70);
    end
    run(80, 1'b1);

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
